// File: rtl/lab_display_driver.sv
// Multiplexed common-anode 7-segment driver with frame-boundary double buffering.
// A CPU write is held pending and only committed to the display at the end of a scan frame.
module lab_display_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic                    disp_en,
    output logic                    wr_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0]        div_cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] disp_reg_r;
    logic [4*NUM_DIGITS-1:0] pend_reg_r;
    logic                    pend_vld_r;
    logic                    wr_ack_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;

    logic                    tick_s;
    logic                    frame_end_s;
    logic [3:0]              nib_s;
    logic                    upper_nz_s;
    logic                    blank_s;
    logic [NUM_DIGITS-1:0]   an_nxt_s;
    logic [6:0]              seg_nxt_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Scan timing, current nibble and leading-zero blanking of the digit being scanned
    always_comb begin
        tick_s      = (div_cnt_r == DIV_LAST);
        frame_end_s = tick_s && (idx_r == IDX_LAST);
        nib_s       = 4'h0;
        upper_nz_s  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib_s      = nib_s | ((int'(idx_r) == k) ? disp_reg_r[4*k +: 4] : 4'h0);
            upper_nz_s = upper_nz_s | ((k >= int'(idx_r)) && (disp_reg_r[4*k +: 4] != 4'h0));
        end
        blank_s = LZ_BLANK && (idx_r != {IDX_W{1'b0}}) && !upper_nz_s;
        if (disp_en && !blank_s) begin
            an_nxt_s  = ~(NUM_DIGITS'(1'b1) << idx_r);
            seg_nxt_s = hex_to_seg(nib_s);
        end else begin
            an_nxt_s  = {NUM_DIGITS{1'b1}};
            seg_nxt_s = 7'h7F;
        end
    end

    // Digit-period divider and digit index
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
        end else if (tick_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_ONE;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
            idx_r     <= idx_r;
        end
    end

    // Write buffer: a strobe landing on the frame_end cycle wins over an older pending value
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            disp_reg_r <= {(4*NUM_DIGITS){1'b0}};
            pend_reg_r <= {(4*NUM_DIGITS){1'b0}};
            pend_vld_r <= 1'b0;
            wr_ack_r   <= 1'b0;
        end else if (frame_end_s && wr_en) begin
            disp_reg_r <= wr_data;
            pend_vld_r <= 1'b0;
            wr_ack_r   <= 1'b1;
        end else if (frame_end_s && pend_vld_r) begin
            disp_reg_r <= pend_reg_r;
            pend_vld_r <= 1'b0;
            wr_ack_r   <= 1'b1;
        end else if (wr_en) begin
            pend_reg_r <= wr_data;
            pend_vld_r <= 1'b1;
            wr_ack_r   <= 1'b0;
        end else begin
            wr_ack_r   <= 1'b0;
        end
    end

    // Registered anode/segment drive
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            an_r  <= {NUM_DIGITS{1'b1}};
            seg_r <= 7'h7F;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign wr_ack = wr_ack_r;
    assign an     = an_r;
    assign seg    = seg_r;

endmodule
